// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and constants
package riscv_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'b111111;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction memory and decode handshakes of the fetch stage
interface instruction_fetch_unit_if;
  import riscv_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  word_t imem_rdata;
  logic  imem_valid;
  word_t instr_out;
  logic  instr_valid;
  logic  instr_ready;

  modport master (
    output imem_req, imem_addr, instr_out, instr_valid,
    input  imem_rdata, imem_valid, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_out, instr_valid,
    output imem_rdata, imem_valid, instr_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC register and fetch FSM; FETCH_TIMEOUT_EN adds a fetch watchdog
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter word_t      RESET_PC    = 32'd0,
  parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int         TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  word_t                     pc_next_in,
  output word_t                     pc_out,
  instruction_fetch_unit_if.master  bus,
  output logic                      halted,
  output word_t                     instr_count
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic                      fetch_error
`endif
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        instr_q, instr_d;
  word_t        count_q, count_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
`ifdef FETCH_TIMEOUT_EN
    err_d   = err_q;
    // Counts cycles spent in FETCH; reads zero on the first FETCH cycle.
    tmo_d   = (state_q == FETCH) ? tmo_q + 1'b1 : '0;
`endif
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (bus.imem_valid) begin
          instr_d = bus.imem_rdata;
          state_d = HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = HALT;
        end
`endif
      end
      HOLD: begin
        if (bus.instr_ready) begin
          count_d = count_q + 32'd1;
          if (instr_q[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE) begin
            state_d = HALT;
          end else begin
            pc_d    = pc_next_in;
            state_d = FETCH;
          end
        end
      end
      HALT: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
`ifdef FETCH_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
`ifdef FETCH_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.imem_req    = (state_q == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = (state_q == HOLD);
  assign pc_out          = pc_q;
  assign halted          = (state_q == HALT);
  assign instr_count     = count_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_error     = err_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
  import riscv_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  word_t pc_next_in, pc_out, instr_count;
  logic  halted;
`ifdef FETCH_TIMEOUT_EN
  logic  fetch_error;
`endif

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(.RESET_PC(32'd0)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_next_in  (pc_next_in),
    .pc_out      (pc_out),
    .bus         (bus),
    .halted      (halted),
    .instr_count (instr_count)
`ifdef FETCH_TIMEOUT_EN
    ,
    .fetch_error (fetch_error)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    word_t pc;
    word_t instr;
  } exp_t;

  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  br_override = 1'b0;
  word_t br_value = '0;
  int    mem_lat = 0;
  bit    mem_enable = 1'b0;
  localparam word_t HALT_ADDR = 32'h41;

  assign pc_next_in = br_override ? br_value : pc_out + 32'd1;

  function automatic word_t mem_word(word_t a);
    if (a == HALT_ADDR) return 32'hFC00_0000;
    return {6'b000001, a[25:0]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expect_accept(word_t pc, word_t instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    sb_q.push_back(e);
  endtask

  task automatic check_reset_values();
    check("rst_pc_out", pc_out, 32'd0);
    check("rst_instr_out", bus.instr_out, 32'd0);
    check("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_instr_count", instr_count, 32'd0);
`ifdef FETCH_TIMEOUT_EN
    check("rst_fetch_error", {31'd0, fetch_error}, 32'd0);
`endif
  endtask

  // Memory: one outstanding read; the response arrives mem_lat cycles after it is seen,
  // even if the requester has been reset in the meantime.
  initial begin
    int    cnt;
    bit    pend;
    word_t addr;
    cnt  = 0;
    pend = 1'b0;
    addr = '0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      bus.imem_valid = 1'b0;
      if (!pend && bus.imem_req && mem_enable) begin
        pend = 1'b1;
        cnt  = mem_lat;
        addr = bus.imem_addr;
      end else if (pend && cnt > 0) begin
        cnt--;
      end
      if (pend && cnt == 0) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = mem_word(addr);
        pend = 1'b0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.instr_valid && bus.instr_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_accept actual_pc=%h expected=none", pc_out);
        end else begin
          e = sb_q.pop_front();
          check("accept_pc", pc_out, e.pc);
          check("accept_instr", bus.instr_out, e.instr);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values();

    // Back-to-back fetches, zero memory latency, branch returns pc+1
    for (int k = 0; k < 4; k++) expect_accept(word_t'(k), 32'h0400_0000 + word_t'(k));
    rst = 1'b0;
    bus.instr_ready = 1'b1;
    mem_enable = 1'b1;
    mem_lat = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("seq_req", {31'd0, bus.imem_req}, 32'd1);
      check("seq_addr", bus.imem_addr, word_t'(k));
      @(negedge clk);
      check("seq_hold_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("seq_hold_req", {31'd0, bus.imem_req}, 32'd0);
    end

    // Three extra cycles of memory latency at address 5
    br_override = 1'b1;
    br_value = 32'd5;
    mem_lat = 3;
    expect_accept(32'd5, 32'h0400_0005);
    @(negedge clk);
    check("seq_count", instr_count, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("lat_req", {31'd0, bus.imem_req}, 32'd1);
      check("lat_addr", bus.imem_addr, 32'd5);
      check("lat_not_valid", {31'd0, bus.instr_valid}, 32'd0);
      @(negedge clk);
    end
    check("lat_valid", {31'd0, bus.instr_valid}, 32'd1);
    check("lat_instr", bus.instr_out, 32'h0400_0005);
    bus.instr_ready = 1'b0;

    // Stall in HOLD, then a ready pulse with a branch target
    repeat (10) begin
      @(negedge clk);
      check("stall_instr", bus.instr_out, 32'h0400_0005);
      check("stall_pc", pc_out, 32'd5);
      check("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
    end
    br_value = 32'h40;
    mem_lat = 0;
    expect_accept(32'h40, 32'h0400_0040);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("branch_req", {31'd0, bus.imem_req}, 32'd1);
    check("branch_addr", bus.imem_addr, 32'h40);
    check("branch_count", instr_count, 32'd5);
    bus.instr_ready = 1'b0;
    @(negedge clk);
    check("branch_valid", {31'd0, bus.instr_valid}, 32'd1);

    // HALT opcode fetched from 0x41
    br_value = HALT_ADDR;
    expect_accept(HALT_ADDR, 32'hFC00_0000);
    bus.instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("prehalt_count", instr_count, 32'd6);
    check("prehalt_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_count", instr_count, 32'd7);
    check("halt_valid", {31'd0, bus.instr_valid}, 32'd0);
    repeat (20) begin
      @(negedge clk);
      check("halt_req", {31'd0, bus.imem_req}, 32'd0);
      check("halt_stay", {31'd0, halted}, 32'd1);
      check("halt_count_stay", instr_count, 32'd7);
    end

    // Reset mid-fetch with the response landing in BOOT
    bus.instr_ready = 1'b0;
    br_override = 1'b0;
    mem_lat = 1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_req", {31'd0, bus.imem_req}, 32'd1);
    check("mid_addr", bus.imem_addr, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    @(negedge clk);
    check("boot_req", {31'd0, bus.imem_req}, 32'd1);
    check("boot_addr", bus.imem_addr, 32'd0);
    check("boot_drop_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("boot_drop_instr", bus.instr_out, 32'd0);
    expect_accept(32'd0, 32'h0400_0000);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    mem_enable = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_count", instr_count, 32'd1);
    check("post_rst_addr", bus.imem_addr, 32'd1);

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers: watchdog trips after 16 FETCH cycles
    rst = 1'b1;
    @(negedge clk);
    check("tmo_rst_error", {31'd0, fetch_error}, 32'd0);
    rst = 1'b0;
    repeat (16) @(negedge clk);
    check("tmo_early_error", {31'd0, fetch_error}, 32'd0);
    check("tmo_early_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    check("tmo_error", {31'd0, fetch_error}, 32'd1);
    check("tmo_halted", {31'd0, halted}, 32'd1);
`endif

    check("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage plus program-counter register, directly upstream of the branch unit.
- Holds the architectural PC and issues word-addressed reads to instruction memory over a req/valid handshake.
- Presents the fetched instruction to decode with a valid/ready handshake.
- On acceptance, loads the next PC that the branch unit computes from pc_out.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- HALT_OPCODE, 6'b111111, opcode (instr[31:26]) that stops fetching once accepted.
- TIMEOUT_CYCLES, 16, watchdog limit in cycles. Used only with FETCH_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_next_in  input  32  next PC from the branch unit (its prog_count_out).
- pc_out  output  32  current PC; drives the branch unit's prog_count_in.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  32  word address of the read; equals pc_out.
- imem_rdata  input  32  instruction word from memory.
- imem_valid  input  1  imem_rdata is valid this cycle.
- instr_out  output  32  instruction register contents.
- instr_valid  output  1  instr_out holds an instruction not yet accepted.
- instr_ready  input  1  decode accepts instr_out this cycle.
- halted  output  1  HALT instruction accepted; fetching stopped.
- instr_count  output  32  number of accepted instructions.
- fetch_error  output  1  watchdog tripped. Present only with FETCH_TIMEOUT_EN.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc_out=RESET_PC, instr_out=0, instr_valid=0, imem_req=0, halted=0, instr_count=0, fetch_error=0.
  - State goes to BOOT.
  - Reset overrides everything, including mid-fetch: an in-flight memory response is discarded.
- States: BOOT, FETCH, HOLD, HALT.
- BOOT:
  - imem_req=0.
  - imem_valid is ignored, which drops stale responses.
  - Moves to FETCH unconditionally on the next cycle.
- FETCH:
  - imem_req=1 and imem_addr=pc_out, both held stable until imem_valid.
  - On imem_valid: instr_out<=imem_rdata, instr_valid<=1, go to HOLD.
  - Minimum latency is request cycle to instr_valid = 1 cycle. Memory latency is unbounded (>=0 extra cycles).
- HOLD:
  - imem_req=0; instr_out and pc_out are stable.
  - On instr_ready:
    - instr_valid<=0 and instr_count<=instr_count+1, wrapping modulo 2^32.
    - If instr_out[31:26]==HALT_OPCODE: go to HALT, halted<=1, pc_out unchanged.
    - Otherwise: pc_out<=pc_next_in and go to FETCH.
  - Without instr_ready: remain in HOLD indefinitely.
- HALT:
  - imem_req=0, instr_valid=0, halted=1.
  - Only rst exits this state.
- Handshakes:
  - imem_valid outside FETCH is ignored.
  - instr_ready while instr_valid=0 has no effect.
- pc_next_in:
  - Sampled only on the accept edge.
  - Word-addressed; any 32-bit value is legal.
  - 32'hFFFFFFFF + 1 wraps to 0 in the branch unit. This block does not check it.
- Throughput: one instruction per 2 cycles at best, with zero memory latency and instr_ready held high.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With the macro defined:
  - A counter runs while in FETCH and clears on entry to FETCH.
  - If it reaches TIMEOUT_CYCLES without imem_valid, fetch_error<=1 (sticky until rst) and the FSM goes to HALT.
- Without the macro: the fetch_error port and the counter do not exist, and FETCH waits forever.

Decomposition:
- Shared package riscv_pkg holds:
  - the fetch state enum (BOOT, FETCH, HOLD, HALT);
  - OPCODE_MSB=31 and OPCODE_LSB=26;
  - HALT_OPCODE default;
  - the 32-bit word typedef.
- Sub-module: none. The optional watchdog is small enough to stay inline.

Test Plan:
- Reset then a memory model with 0 extra latency, instr_ready=1, and a branch model returning pc+1:
  - imem_addr is 0, 1, 2, 3 on alternate cycles;
  - instr_count=4 after 8 cycles.
- Memory latency 3 cycles at addr 5: imem_req stays high with imem_addr=5 for 4 cycles, and instr_valid rises the cycle after imem_valid.
- HOLD with instr_ready=0 for 10 cycles: instr_out and pc_out are unchanged. Ready then pulses with pc_next_in=32'h40: next imem_addr=32'h40.
- Fetched word 32'hFC000000 (HALT) is accepted: halted=1, imem_req stays 0 for 20 cycles, and instr_count increments once.
- rst asserted in FETCH while memory returns data 1 cycle later:
  - outputs match reset values;
  - the stale response is dropped in BOOT;
  - the next request is at RESET_PC.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=16, memory never answers: fetch_error=1 and halted=1 exactly 16 cycles after entering FETCH.
